reg_write_arbiter: RTL
======================

# reg_write_arbiter

Shares the single write port of the 8 x 8-bit register file between two writeback requesters: the ALU result path and the memory-load path. Each requester hands its write over with a valid/ready handshake into a one-entry holding slot. The arbiter issues at most one registered write per cycle to the register file and preserves arrival order. It also exports a per-register pending-write mask that the issue logic uses for hazard stalls.

## Interface
- No parameters: data width fixed at 8 bits, address width at 3 bits (8 registers).
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  reset RESET, synchronous, active-high; clock CLK.
- ALU_VALID  in  1  ALU requests a register write.
- ALU_ADDR  in  3  destination register of ALU write.
- ALU_DATA  in  8  ALU write data.
- ALU_READY  out  1  ALU slot can accept this cycle.
- MEM_VALID  in  1  load unit requests a register write.
- MEM_ADDR  in  3  destination register of load write.
- MEM_DATA  in  8  load write data.
- MEM_READY  out  1  MEM slot can accept this cycle.
- RF_WRITE  out  1  write enable to register file (registered).
- RF_INADDRESS  out  3  write address to register file (registered).
- RF_IN  out  8  write data to register file (registered).
- BUSY  out  8  bit i = a write to register i is accepted but not yet committed.

## Operation
- State: two slots (ALU, MEM), each holding full flag, addr, data and age bit; output register (RF_WRITE/RF_INADDRESS/RF_IN); round-robin pointer RR (0 = ALU next, 1 = MEM next).
- Accept: a transfer occurs on a posedge where VALID && READY. A slot captures addr and data and becomes full.
- READY = !RESET && (slot empty || slot granted this cycle). A slot may be issued and refilled on the same edge.
- Grant, evaluated each cycle from the slot state before the edge:
  - Only one slot full: that slot wins.
  - Both full, different arrival edges: the older slot wins. This is mandatory so same-address writes commit in arrival order.
  - Both full, accepted on the same edge: RR picks the winner, then RR flips to the loser.
  - Neither full: no grant.
- Issue: on the edge, the winner's addr/data load into the output register, RF_WRITE <= 1, and the winner slot clears (unless refilled). With no grant, RF_WRITE <= 0; RF_INADDRESS/RF_IN hold their previous value.
- Age: a slot filled while the other slot is full and not being granted is marked younger. When both slots fill on the same edge they are tied.
- BUSY (combinational from state): OR of one-hot(addr) for each full slot, plus one-hot(RF_INADDRESS) while RF_WRITE = 1.
- Throughput: at most one write issued per cycle in total. Sustained simultaneous requests alternate ALU/MEM.

## Timing
- Reset: all slots empty, RR = 0, RF_WRITE = 0, RF_INADDRESS = 0, RF_IN = 0, BUSY = 0, ALU_READY = MEM_READY = 0 while RESET is high. Both READY go to 1 in the first cycle after RESET deasserts.
- Reset mid-operation: pending slot contents and an in-flight output write are discarded. RF_WRITE is 0 after the reset edge, and no stale write is ever issued afterwards.
- Latency: accepted at edge N → RF_WRITE = 1 after edge N+1 (if uncontested) → register file captures at edge N+2. BUSY[addr] is high from after edge N until after edge N+2.
- Loser latency: +1 cycle per lost grant. Worst case 2 cycles from accept to issue.
- Back-pressure: a slot holding a losing entry deasserts READY until it is granted. A requester must hold VALID/ADDR/DATA stable while READY = 0.
- Same address in both slots, same edge: both writes issue on consecutive cycles in RR order, and the final register value is the later-issued data.

## Test plan
- Single write: after reset, ALU_VALID=1, ADDR=3, DATA=0x55 for one cycle → next cycle RF_WRITE=1, RF_INADDRESS=3, RF_IN=0x55 for exactly one cycle; BUSY=0x08 for 2 cycles, then 0x00.
- Simultaneous, tie: ALU(2,0x11) and MEM(5,0x22) on the same edge after reset → RF writes (2,0x11) then (5,0x22) on consecutive cycles; MEM_READY=0 for one cycle; BUSY=0x24, then 0x24, then 0x20.
- Age ordering: MEM(4,0xAA) accepted, next edge ALU(4,0xBB) accepted → writes issue (4,0xAA) then (4,0xBB); register 4 ends at 0xBB.
- Streaming: both VALID held high for 8 cycles with incrementing data → RF_WRITE=1 every cycle, grants strictly alternate ALU/MEM; no request is dropped or duplicated.
- Reset mid-flight: both slots full and RF_WRITE=1, then assert RESET for one cycle → RF_WRITE=0, BUSY=0, READY=0 during reset; no write issues afterwards until a new request arrives.
- Back-pressure hold: both slots full, ALU presents a new request while ALU_READY=0 → it is accepted only on the edge its slot is granted; data is captured exactly once.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: merges ALU and load-unit writebacks onto the single
// register-file write port. Each requester owns a one-entry slot; the older
// slot always issues first so same-address writes commit in arrival order,
// and simultaneous arrivals are broken by a round-robin pointer.
module reg_write_arbiter (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ALU_VALID,
    input  logic [2:0] ALU_ADDR,
    input  logic [7:0] ALU_DATA,
    output logic       ALU_READY,
    input  logic       MEM_VALID,
    input  logic [2:0] MEM_ADDR,
    input  logic [7:0] MEM_DATA,
    output logic       MEM_READY,
    output logic       RF_WRITE,
    output logic [2:0] RF_INADDRESS,
    output logic [7:0] RF_IN,
    output logic [7:0] BUSY
);

    logic       aluFull_q, aluFull_d;
    logic [2:0] aluAddr_q, aluAddr_d;
    logic [7:0] aluData_q, aluData_d;
    logic       aluYoung_q, aluYoung_d;
    logic       memFull_q, memFull_d;
    logic [2:0] memAddr_q, memAddr_d;
    logic [7:0] memData_q, memData_d;
    logic       memYoung_q, memYoung_d;
    logic       rr_q, rr_d;
    logic       rfWrite_q, rfWrite_d;
    logic [2:0] rfAddr_q, rfAddr_d;
    logic [7:0] rfData_q, rfData_d;

    logic       tie;
    logic       aluGrant;
    logic       memGrant;
    logic       aluAccept;
    logic       memAccept;

    // Pick the winner from pre-edge slot state: age first, round-robin on a tie.
    always_comb begin
        tie       = aluFull_q && memFull_q && !aluYoung_q && !memYoung_q;
        aluGrant  = aluFull_q && (!memFull_q || memYoung_q || (tie && !rr_q));
        memGrant  = memFull_q && (!aluFull_q || aluYoung_q || (tie && rr_q));
        ALU_READY = !RESET && (!aluFull_q || aluGrant);
        MEM_READY = !RESET && (!memFull_q || memGrant);
        aluAccept = ALU_VALID && ALU_READY;
        memAccept = MEM_VALID && MEM_READY;
    end

    // Next state: issue the winner, refill or clear slots, and track relative age.
    always_comb begin
        aluFull_d  = aluFull_q;
        aluAddr_d  = aluAddr_q;
        aluData_d  = aluData_q;
        aluYoung_d = aluYoung_q;
        memFull_d  = memFull_q;
        memAddr_d  = memAddr_q;
        memData_d  = memData_q;
        memYoung_d = memYoung_q;
        rr_d       = rr_q;
        rfWrite_d  = 1'b0;
        rfAddr_d   = rfAddr_q;
        rfData_d   = rfData_q;

        if (aluGrant) begin
            rfWrite_d = 1'b1;
            rfAddr_d  = aluAddr_q;
            rfData_d  = aluData_q;
        end else if (memGrant) begin
            rfWrite_d = 1'b1;
            rfAddr_d  = memAddr_q;
            rfData_d  = memData_q;
        end

        if (tie) begin
            rr_d = aluGrant;
        end

        if (aluAccept) begin
            aluFull_d  = 1'b1;
            aluAddr_d  = ALU_ADDR;
            aluData_d  = ALU_DATA;
            aluYoung_d = memFull_q && !memGrant;
        end else if (aluGrant) begin
            aluFull_d  = 1'b0;
            aluYoung_d = 1'b0;
        end else begin
            aluYoung_d = aluYoung_q && !memGrant;
        end

        if (memAccept) begin
            memFull_d  = 1'b1;
            memAddr_d  = MEM_ADDR;
            memData_d  = MEM_DATA;
            memYoung_d = aluFull_q && !aluGrant;
        end else if (memGrant) begin
            memFull_d  = 1'b0;
            memYoung_d = 1'b0;
        end else begin
            memYoung_d = memYoung_q && !aluGrant;
        end
    end

    // State register; reset discards pending slots and any in-flight write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            aluFull_q  <= 1'b0;
            aluAddr_q  <= 3'd0;
            aluData_q  <= 8'd0;
            aluYoung_q <= 1'b0;
            memFull_q  <= 1'b0;
            memAddr_q  <= 3'd0;
            memData_q  <= 8'd0;
            memYoung_q <= 1'b0;
            rr_q       <= 1'b0;
            rfWrite_q  <= 1'b0;
            rfAddr_q   <= 3'd0;
            rfData_q   <= 8'd0;
        end else begin
            aluFull_q  <= aluFull_d;
            aluAddr_q  <= aluAddr_d;
            aluData_q  <= aluData_d;
            aluYoung_q <= aluYoung_d;
            memFull_q  <= memFull_d;
            memAddr_q  <= memAddr_d;
            memData_q  <= memData_d;
            memYoung_q <= memYoung_d;
            rr_q       <= rr_d;
            rfWrite_q  <= rfWrite_d;
            rfAddr_q   <= rfAddr_d;
            rfData_q   <= rfData_d;
        end
    end

    // Pending-write mask: both slots plus the write currently on the port.
    always_comb begin
        BUSY = 8'd0;
        if (aluFull_q) begin
            BUSY = BUSY | (8'd1 << aluAddr_q);
        end
        if (memFull_q) begin
            BUSY = BUSY | (8'd1 << memAddr_q);
        end
        if (rfWrite_q) begin
            BUSY = BUSY | (8'd1 << rfAddr_q);
        end
    end

    assign RF_WRITE     = rfWrite_q;
    assign RF_INADDRESS = rfAddr_q;
    assign RF_IN        = rfData_q;

endmodule
